pixel_stream_reader: RTL

Read-side engine for the pixel image storage block. On a start pulse it walks one frame of `IMG_W*IMG_H` pixels through the memory's read port, absorbing the memory's fixed one-cycle read latency. It delivers pixels in raster order on a valid/ready stream to the downstream processing stage, and a 4-entry output buffer provides full throughput under backpressure.

---
 rtl/pixel_stream_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: walks one IMG_W*IMG_H frame out of the pixel store's
// read port and delivers it in raster order on a valid/ready stream through
// a 4-entry buffer.
// Optional feature: define PIXEL_READER_EOL_EN to add the pix_eol output.
module pixel_stream_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
`ifdef PIXEL_READER_EOL_EN
  output logic              pix_eol,
`endif
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned OCC_W = 3;
  localparam int unsigned SUM_W = 4;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state, next_state;
  logic               start_c, issue_c;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   rx_cnt, rx_n;
  logic               rd_d;
  logic [DATA_W-1:0]  buf_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [OCC_W-1:0]   count, count_n;
  logic               push_c, pop_c;
  logic [DATA_W-1:0]  head_n;
  logic [SUM_W-1:0]   pending_c;

  assign mem_wren = 1'b0;
  // Combinational so that it lands in the same cycle as the final transfer.
  assign done = pix_valid & pix_ready & pix_last;

  // Buffered pixels plus reads still on their way to the buffer.
  assign pending_c = SUM_W'(count) + SUM_W'(mem_rden) + SUM_W'(rd_d);

  // Next-state and issue decision; a new read is allowed only when the
  // buffer can hold it even if nothing drains in the meantime.
  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    issue_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_c    = 1'b1;
          next_state = (NPIX == 1) ? DRAIN : READ;
        end
      end
      READ: begin
        if (pending_c <= SUM_W'(DEPTH - 1)) begin
          issue_c = 1'b1;
          if (issued == CNT_W'(NPIX - 1)) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Buffer bookkeeping for the coming edge, including the next head value.
  always_comb begin
    push_c   = rd_d;
    pop_c    = pix_valid & pix_ready;
    rd_ptr_n = rd_ptr + PTR_W'(pop_c);
    count_n  = count + OCC_W'(push_c) - OCC_W'(pop_c);
    rx_n     = rx_cnt + CNT_W'(pop_c);
    head_n   = buf_q[rd_ptr_n];
    if (push_c && (wr_ptr == rd_ptr_n)) head_n = mem_q;
  end

  // State, read issue, buffer pointers and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      base_q    <= '0;
      issued    <= '0;
      mem_addr  <= '0;
      mem_rden  <= 1'b0;
      rd_d      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_cnt    <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      state    <= next_state;
      busy     <= (next_state != IDLE);
      mem_rden <= start_c | issue_c;
      rd_d     <= mem_rden;
      if (start_c) begin
        base_q   <= base_addr;
        mem_addr <= base_addr;
        issued   <= CNT_W'(1);
      end else if (issue_c) begin
        mem_addr <= base_q + ADDR_W'(issued);
        issued   <= issued + CNT_W'(1);
      end
      if (start_c) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        rx_cnt    <= '0;
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        rd_ptr    <= rd_ptr_n;
        count     <= count_n;
        rx_cnt    <= rx_n;
        pix_valid <= (count_n != '0);
        pix_last  <= (count_n != '0) && (rx_n == CNT_W'(NPIX - 1));
        if (count_n != '0) pix_data <= head_n;
      end
    end
  end

  // Buffer storage; read data arrives one cycle after each issued read.
  always_ff @(posedge clk) begin
    if (push_c) buf_q[wr_ptr] <= mem_q;
  end

`ifdef PIXEL_READER_EOL_EN
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [COL_W-1:0] col, col_n;

  // Line position of the head pixel, advancing on each transfer.
  always_comb begin
    col_n = col;
    if (pop_c) col_n = (col == COL_W'(IMG_W - 1)) ? '0 : col + COL_W'(1);
  end

  // End-of-line flag aligned with the head pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      pix_eol <= 1'b0;
    end else if (start_c) begin
      col     <= '0;
      pix_eol <= 1'b0;
    end else begin
      col     <= col_n;
      pix_eol <= (count_n != '0) && (col_n == COL_W'(IMG_W - 1));
    end
  end
`endif

endmodule
